// File: rtl/bitstream_byte_feeder.sv
// Purpose: byte FIFO between the slice-payload stream and the arithmetic decoder, removing 0x00 0x00 0x03 emulation-prevention bytes.
// Latency: a byte accepted in cycle N appears on data in cycle N+1; request_byte pops the head combinationally in the same cycle.
// Backpressure: s_ready drops when the FIFO is full or during flush; a request on an empty FIFO raises stall and the sticky underflow flag.
module bitstream_byte_feeder #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              epb_en,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic [7:0]        data,
    output logic              data_valid,
    input  logic              request_byte,
    output logic              stall,
    output logic              underflow,
    output logic [ADDR_W:0]   level,
    output logic [15:0]       epb_count
);

    localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W + 1)'(DEPTH);

    logic [7:0]        mem [DEPTH];

    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic [1:0]        zero_run_q, zero_run_d;
    logic              underflow_q, underflow_d;
    logic [15:0]       epb_count_q, epb_count_d;

    logic full;
    logic empty;
    logic accept;
    logic drop;
    logic wr_en;
    logic pop;

    // Handshake qualification: flush blocks both sides, a full FIFO never accepts even when popping.
    always_comb begin
        full   = (level_q == FULL_LVL);
        empty  = (level_q == '0);
        accept = s_valid && !full && !flush;
        drop   = accept && epb_en && (zero_run_q == 2'd2) && (s_data == 8'h03);
        wr_en  = accept && !drop;
        pop    = request_byte && !empty && !flush;
    end

    // Next-state for pointers, fill level, zero-run tracker and status; flush overrides everything.
    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        level_d     = level_q;
        zero_run_d  = zero_run_q;
        underflow_d = underflow_q;
        epb_count_d = epb_count_q;

        if (flush) begin
            rd_ptr_d    = '0;
            wr_ptr_d    = '0;
            level_d     = '0;
            zero_run_d  = 2'd0;
            underflow_d = 1'b0;
            epb_count_d = 16'd0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + ADDR_W'(1);
            end

            case ({wr_en, pop})
                2'b10:   level_d = level_q + (ADDR_W + 1)'(1);
                2'b01:   level_d = level_q - (ADDR_W + 1)'(1);
                default: level_d = level_q;
            endcase

            // zero_run tracks even with removal disabled so enabling mid-stream is consistent.
            if (accept) begin
                if (drop) begin
                    zero_run_d = 2'd0;
                end else if (s_data == 8'h00) begin
                    zero_run_d = (zero_run_q == 2'd2) ? 2'd2 : zero_run_q + 2'd1;
                end else begin
                    zero_run_d = 2'd0;
                end
            end

            if (drop && (epb_count_q != 16'hFFFF)) begin
                epb_count_d = epb_count_q + 16'd1;
            end

            if (request_byte && empty) begin
                underflow_d = 1'b1;
            end
        end
    end

    // Control state registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            level_q     <= '0;
            zero_run_q  <= 2'd0;
            underflow_q <= 1'b0;
            epb_count_q <= 16'd0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            level_q     <= level_d;
            zero_run_q  <= zero_run_d;
            underflow_q <= underflow_d;
            epb_count_q <= epb_count_d;
        end
    end

    // Byte storage; contents need no reset because level gates visibility.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= s_data;
        end
    end

    // Outputs are decoded from registered state; no write-to-read bypass.
    always_comb begin
        s_ready    = !full && !flush;
        data_valid = !empty;
        data       = empty ? 8'h00 : mem[rd_ptr_q];
        stall      = request_byte && empty && !flush;
        underflow  = underflow_q;
        level      = level_q;
        epb_count  = epb_count_q;
    end

endmodule

// File: tb/tb_bitstream_byte_feeder.sv
// Directed bench for bitstream_byte_feeder: expected bytes are queued as stimulus is issued,
// and a negedge monitor checks each consumed head byte against that queue.
module tb_bitstream_byte_feeder;

    logic       clk;
    logic       reset_n;
    logic       flush;
    logic       epb_en;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_ready;
    logic [7:0] data;
    logic       data_valid;
    logic       request_byte;
    logic       stall;
    logic       underflow;
    logic [3:0] level;
    logic [15:0] epb_count;

    int checks   = 0;
    int failures = 0;
    logic [7:0] sb [$];

    bitstream_byte_feeder #(.DEPTH(8), .ADDR_W(3)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .flush        (flush),
        .epb_en       (epb_en),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_ready      (s_ready),
        .data         (data),
        .data_valid   (data_valid),
        .request_byte (request_byte),
        .stall        (stall),
        .underflow    (underflow),
        .level        (level),
        .epb_count    (epb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every real pop must present the oldest expected byte.
    always @(negedge clk) begin
        if (reset_n && request_byte && !flush && data_valid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL pop_unexpected actual=0x%0h expected=no_byte", data);
            end else begin
                check("pop_data", int'(data), int'(sb.pop_front()));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        s_valid = 1'b1;
        s_data  = b;
        cyc();
        s_valid = 1'b0;
    endtask

    task automatic drain();
        request_byte = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (sb.size() == 0) break;
            cyc();
        end
        request_byte = 1'b0;
        #1;
        check("drain_empty", sb.size(), 0);
        check("drain_level", int'(level), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] exp1 [3];
        logic [7:0] seq  [8];
        int sent;
        bit acc;
        bit rq;

        exp1 = '{8'h3C, 8'h7E, 8'h00};
        seq  = '{8'h00, 8'h00, 8'h03, 8'h01, 8'h00, 8'h00, 8'h03, 8'h03};

        reset_n = 1'b0; flush = 1'b0; epb_en = 1'b0;
        s_valid = 1'b0; s_data = 8'h00; request_byte = 1'b0;
        #12;
        check("rst_level", int'(level), 0);
        check("rst_data", int'(data), 0);
        check("rst_data_valid", int'(data_valid), 0);
        check("rst_stall", int'(stall), 0);
        check("rst_s_ready", int'(s_ready), 1);
        check("rst_epb_count", int'(epb_count), 0);
        @(negedge clk);
        reset_n = 1'b1;
        cyc();

        // Basic flow
        sb.push_back(8'hA5); push(8'hA5);
        #1;
        check("basic_first_valid", int'(data_valid), 1);
        check("basic_first_data", int'(data), 8'hA5);
        sb.push_back(8'h3C); push(8'h3C);
        sb.push_back(8'h7E); push(8'h7E);
        #1;
        check("basic_level3", int'(level), 3);
        check("basic_head", int'(data), 8'hA5);
        for (int i = 0; i < 3; i++) begin
            request_byte = 1'b1;
            cyc();
            request_byte = 1'b0;
            #1;
            check("basic_after_pop", int'(data), int'(exp1[i]));
        end
        check("basic_empty_valid", int'(data_valid), 0);
        check("basic_empty_level", int'(level), 0);

        // Emulation-prevention removal
        epb_en = 1'b1;
        sb.push_back(8'h00); sb.push_back(8'h00); sb.push_back(8'h01);
        sb.push_back(8'h00); sb.push_back(8'h00); sb.push_back(8'h03);
        for (int i = 0; i < 8; i++) push(seq[i]);
        #1;
        check("epb_level", int'(level), 6);
        check("epb_count2", int'(epb_count), 2);
        drain();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        #1;
        check("epb_flush_count", int'(epb_count), 0);

        // Same stream with removal disabled fills the FIFO
        epb_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sb.push_back(seq[i]);
            push(seq[i]);
        end
        #1;
        check("noepb_level", int'(level), 8);
        check("noepb_count", int'(epb_count), 0);
        check("full_s_ready", int'(s_ready), 0);

        // Pop and push together at full: only the pop happens
        s_valid = 1'b1; s_data = 8'h99; request_byte = 1'b1;
        #1;
        check("full_hold_ready", int'(s_ready), 0);
        cyc();
        request_byte = 1'b0;
        #1;
        check("full_pop_only_level", int'(level), 7);
        check("full_ready_again", int'(s_ready), 1);
        sb.push_back(8'h99);
        cyc();
        sent = 9;

        // Random pops across pointer wrap; the queue length mirrors the expected level
        for (int k = 0; k < 300 && sent < 20; k++) begin
            acc = (sb.size() < 8);
            rq  = (sb.size() != 0) && ($urandom_range(0, 1) == 1);
            s_valid      = 1'b1;
            s_data       = 8'(8'h40 + sent);
            request_byte = rq;
            #1;
            check("wrap_s_ready", int'(s_ready), int'(acc));
            if (acc) begin
                sb.push_back(s_data);
                sent++;
            end
            cyc();
        end
        s_valid = 1'b0;
        request_byte = 1'b0;
        check("wrap_sent", sent, 20);
        drain();

        // Underflow
        request_byte = 1'b1;
        #1;
        check("uf_stall", int'(stall), 1);
        cyc();
        request_byte = 1'b0;
        #1;
        check("uf_sticky", int'(underflow), 1);
        check("uf_level", int'(level), 0);
        check("uf_stall_clear", int'(stall), 0);
        sb.push_back(8'h11); push(8'h11);
        #1;
        check("uf_push_data", int'(data), 8'h11);
        check("uf_still_set", int'(underflow), 1);

        // Flush mid-stream
        epb_en = 1'b1;
        sb.push_back(8'h00); sb.push_back(8'h00); sb.push_back(8'h21); sb.push_back(8'h22);
        push(8'h00); push(8'h00); push(8'h03); push(8'h21); push(8'h22);
        #1;
        check("fl_pre_level", int'(level), 5);
        check("fl_pre_epb", int'(epb_count), 1);
        check("fl_pre_uf", int'(underflow), 1);
        flush = 1'b1; s_valid = 1'b1; s_data = 8'h55; request_byte = 1'b1;
        #1;
        check("fl_s_ready", int'(s_ready), 0);
        check("fl_valid_held", int'(data_valid), 1);
        check("fl_no_stall", int'(stall), 0);
        cyc();
        flush = 1'b0; s_valid = 1'b0; request_byte = 1'b0;
        sb.delete();
        #1;
        check("fl_level", int'(level), 0);
        check("fl_uf", int'(underflow), 0);
        check("fl_epb", int'(epb_count), 0);
        check("fl_s_ready_after", int'(s_ready), 1);
        check("fl_valid_after", int'(data_valid), 0);

        // Asynchronous reset mid-operation, with zero_run left at 2
        push(8'h31); push(8'h32); push(8'h00); push(8'h00);
        #1;
        check("ar_pre_level", int'(level), 4);
        #1;
        reset_n = 1'b0;
        #1;
        check("ar_level", int'(level), 0);
        check("ar_valid", int'(data_valid), 0);
        check("ar_data", int'(data), 0);
        @(negedge clk);
        reset_n = 1'b1;
        cyc();
        sb.push_back(8'h03); sb.push_back(8'h00); sb.push_back(8'h00);
        push(8'h03); push(8'h00); push(8'h00); push(8'h03);
        #1;
        check("ar_post_level", int'(level), 3);
        check("ar_post_epb", int'(epb_count), 1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
